// File: rtl/mem_pkg.sv
// Shared line/word geometry and FSM encoding for the word-to-line memory bridge.
package mem_pkg;
  localparam int LINE_BYTES = 16;
  localparam int WORD_BYTES = 4;
  localparam int LINE_W     = LINE_BYTES * 8;
  localparam int WORD_W     = WORD_BYTES * 8;
  localparam int LANES      = LINE_BYTES / WORD_BYTES;
  localparam int LANE_W     = $clog2(LANES);

  typedef enum logic [2:0] {
    IDLE,
    RADDR,
    RDATA,
    WRITE,
    WRESP,
    RESP
  } state_t;
endpackage

// File: rtl/word_lane_map.sv
// Maps one 32-bit word onto its lane of a 128-bit line (write replicate/strobe, read extract).
// Purely combinational, no backpressure.
module word_lane_map
  import mem_pkg::*;
(
  input  logic [LANE_W-1:0]     lane,
  input  logic [WORD_W-1:0]     wdata,
  input  logic [WORD_BYTES-1:0] wmask,
  input  logic [LINE_W-1:0]     line_rdata,
  output logic [LINE_W-1:0]     line_wdata,
  output logic [LINE_BYTES-1:0] line_strb,
  output logic [WORD_W-1:0]     word_rdata
);
  // Data goes to every lane; only the strobe picks the addressed word.
  assign line_wdata = {LANES{wdata}};
  assign line_strb  = LINE_BYTES'(wmask) << (lane * WORD_BYTES);
  assign word_rdata = line_rdata[lane * WORD_W +: WORD_W];
endmodule

// File: rtl/mem_req_bridge.sv
// Single-outstanding word request to AXI-Lite line bridge; read latency 3 cycles with a zero-wait slave.
// req_ready only in IDLE; response held until rsp_ready; AXI valids never depend on AXI readies.
module mem_req_bridge
  import mem_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [31:0]  req_addr,
  input  logic [31:0]  req_wdata,
  input  logic [3:0]   req_wmask,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [31:0]  rsp_rdata,
  output logic [31:0]  readAddr_addr,
  output logic         readAddr_valid,
  input  logic         readAddr_ready,
  input  logic [127:0] readData_data,
  input  logic         readData_valid,
  output logic         readData_ready,
  output logic [31:0]  writeAddr_addr,
  output logic         writeAddr_valid,
  input  logic         writeAddr_ready,
  output logic [127:0] writeData_data,
  output logic [15:0]  writeData_strb,
  output logic         writeData_valid,
  input  logic         writeData_ready,
  input  logic [31:0]  writeResp_msg,
  input  logic         writeResp_valid,
  output logic         writeResp_ready
);
  state_t                    state, state_nxt;
  logic [ADDR_W-1:2]         addr_q;
  logic [WORD_W-1:0]         wdata_q;
  logic [WORD_BYTES-1:0]     wmask_q;
  logic [WORD_W-1:0]         rdata_q;
  logic                      aw_done, w_done;
  logic [31:0]               line_addr;
  logic [LINE_W-1:0]         line_wdata;
  logic [LINE_BYTES-1:0]     line_strb;
  logic [WORD_W-1:0]         lane_rdata;
  logic                      unused_bits;

  assign line_addr   = 32'({addr_q[ADDR_W-1:4], 4'b0000});
  assign unused_bits = ^{writeResp_msg, req_addr[31:ADDR_W], req_addr[1:0]};

  word_lane_map u_lane_map (
    .lane       (addr_q[3:2]),
    .wdata      (wdata_q),
    .wmask      (wmask_q),
    .line_rdata (readData_data),
    .line_wdata (line_wdata),
    .line_strb  (line_strb),
    .word_rdata (lane_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (req_valid) begin
          addr_q  <= req_addr[ADDR_W-1:2];
          wdata_q <= req_wdata;
          wmask_q <= req_wmask;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end
        RDATA: if (readData_valid) rdata_q <= lane_rdata;
        WRITE: begin
          // Each channel retires independently so its valid drops after its own handshake.
          if (writeAddr_ready) aw_done <= 1'b1;
          if (writeData_ready) w_done  <= 1'b1;
        end
        WRESP: if (writeResp_valid) rdata_q <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt       = state;
    req_ready       = 1'b0;
    rsp_valid       = 1'b0;
    rsp_rdata       = '0;
    readAddr_valid  = 1'b0;
    readAddr_addr   = '0;
    readData_ready  = 1'b0;
    writeAddr_valid = 1'b0;
    writeAddr_addr  = '0;
    writeData_valid = 1'b0;
    writeData_data  = '0;
    writeData_strb  = '0;
    writeResp_ready = 1'b0;
    case (state)
      IDLE: begin
        req_ready = rst_n;
        if (req_valid && rst_n) state_nxt = req_we ? WRITE : RADDR;
      end
      RADDR: begin
        readAddr_valid = 1'b1;
        readAddr_addr  = line_addr;
        if (readAddr_ready) state_nxt = RDATA;
      end
      RDATA: begin
        readData_ready = 1'b1;
        if (readData_valid) state_nxt = RESP;
      end
      WRITE: begin
        if (!aw_done) begin
          writeAddr_valid = 1'b1;
          writeAddr_addr  = line_addr;
        end
        if (!w_done) begin
          writeData_valid = 1'b1;
          writeData_data  = line_wdata;
          writeData_strb  = line_strb;
        end
        if ((aw_done || writeAddr_ready) && (w_done || writeData_ready)) state_nxt = WRESP;
      end
      WRESP: begin
        writeResp_ready = 1'b1;
        if (writeResp_valid) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_req_bridge.sv
// Bench for mem_req_bridge: AXI-Lite SRAM slave with programmable delays, byte-level reference memory.
module tb_mem_req_bridge;
  logic         clk;
  logic         rst_n;
  logic         req_valid, req_ready, req_we;
  logic [31:0]  req_addr, req_wdata;
  logic [3:0]   req_wmask;
  logic         rsp_valid, rsp_ready;
  logic [31:0]  rsp_rdata;
  logic [31:0]  readAddr_addr;
  logic         readAddr_valid, readAddr_ready;
  logic [127:0] readData_data;
  logic         readData_valid, readData_ready;
  logic [31:0]  writeAddr_addr;
  logic         writeAddr_valid, writeAddr_ready;
  logic [127:0] writeData_data;
  logic [15:0]  writeData_strb;
  logic         writeData_valid, writeData_ready;
  logic [31:0]  writeResp_msg;
  logic         writeResp_valid, writeResp_ready;

  mem_req_bridge #(.ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .readAddr_addr(readAddr_addr), .readAddr_valid(readAddr_valid), .readAddr_ready(readAddr_ready),
    .readData_data(readData_data), .readData_valid(readData_valid), .readData_ready(readData_ready),
    .writeAddr_addr(writeAddr_addr), .writeAddr_valid(writeAddr_valid), .writeAddr_ready(writeAddr_ready),
    .writeData_data(writeData_data), .writeData_strb(writeData_strb), .writeData_valid(writeData_valid),
    .writeData_ready(writeData_ready), .writeResp_msg(writeResp_msg), .writeResp_valid(writeResp_valid),
    .writeResp_ready(writeResp_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_err = 0;
  int n_chk = 0;

  // Reference memory (bytes) and slave SRAM (lines), preloaded identically.
  logic [7:0]   ref_mem [0:65535];
  logic [127:0] lines   [0:4095];

  // Slave configuration (written by the test) and state/monitor counters (owned by the slave).
  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  bit r_pend, aw_got, w_got, b_pend, aw_in_txn;
  int r_cnt, ar_cnt, aw_cnt, w_cnt, b_cnt;
  logic [11:0]  r_line;
  logic [31:0]  last_raddr, last_waddr;
  logic [127:0] last_wdata;
  logic [15:0]  last_wstrb;
  int aw_hs_n = 0, w_hs_n = 0, wv_cycles = 0, av_cycles = 0, b_early_n = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    int b;
    b = int'({a[15:2], 2'b00});
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    int b;
    b = int'({a[15:2], 2'b00});
    for (int i = 0; i < 4; i++) if (m[i]) ref_mem[b+i] = d[8*i +: 8];
  endtask

  // AXI-Lite SRAM slave: decides readies/valids at the falling edge, handshakes land on the next rising edge.
  initial begin
    readAddr_ready = 0; readData_valid = 0; readData_data = '0;
    writeAddr_ready = 0; writeData_ready = 0; writeResp_valid = 0; writeResp_msg = '0;
    r_pend = 0; aw_got = 0; w_got = 0; b_pend = 0; aw_in_txn = 0;
    r_cnt = 0; ar_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    r_line = '0; last_raddr = '0; last_waddr = '0; last_wdata = '0; last_wstrb = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        readAddr_ready = 0; readData_valid = 0; writeAddr_ready = 0;
        writeData_ready = 0; writeResp_valid = 0;
        r_pend = 0; aw_got = 0; w_got = 0; b_pend = 0; aw_in_txn = 0;
        r_cnt = 0; ar_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      end else begin
        if (writeData_valid) wv_cycles++;
        if (writeAddr_valid) av_cycles++;
        if (writeResp_ready && !aw_in_txn) b_early_n++;
        readData_valid = 0;
        if (r_pend) begin
          if (r_cnt >= r_dly) begin
            readData_valid = 1;
            readData_data  = lines[r_line];
            if (readData_ready) r_pend = 0;
          end else r_cnt++;
        end
        readAddr_ready = 0;
        if (readAddr_valid) begin
          if (ar_cnt >= ar_dly) begin
            readAddr_ready = 1; r_pend = 1; r_cnt = 0; ar_cnt = 0;
            r_line = readAddr_addr[15:4]; last_raddr = readAddr_addr;
          end else ar_cnt++;
        end else ar_cnt = 0;
        writeResp_valid = 0;
        if (b_pend) begin
          if (b_cnt >= b_dly) begin
            writeResp_valid = 1;
            if (writeResp_ready) begin b_pend = 0; aw_in_txn = 0; end
          end else b_cnt++;
        end
        writeAddr_ready = 0;
        if (writeAddr_valid) begin
          if (aw_cnt >= aw_dly) begin
            writeAddr_ready = 1; aw_got = 1; aw_in_txn = 1; aw_cnt = 0; aw_hs_n++;
            last_waddr = writeAddr_addr;
          end else aw_cnt++;
        end else aw_cnt = 0;
        writeData_ready = 0;
        if (writeData_valid) begin
          if (w_cnt >= w_dly) begin
            writeData_ready = 1; w_got = 1; w_cnt = 0; w_hs_n++;
            last_wdata = writeData_data; last_wstrb = writeData_strb;
          end else w_cnt++;
        end else w_cnt = 0;
        if (aw_got && w_got) begin
          for (int i = 0; i < 16; i++)
            if (last_wstrb[i]) lines[last_waddr[15:4]][8*i +: 8] = last_wdata[8*i +: 8];
          aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0;
        end
      end
    end
  end

  // One request from offer to response handshake; rsp_ready held low for rwait cycles first.
  task automatic do_req(input logic we_i, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m,
                        input int rwait, output logic [31:0] rd, output int lat, output bit stable, output bit to);
    int n;
    to = 0; stable = 1; lat = 0; rd = '0;
    @(negedge clk);
    req_valid = 1; req_we = we_i; req_addr = a; req_wdata = wd; req_wmask = m;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (req_ready !== 1'b1) begin to = 1; req_valid = 0; return; end
    @(negedge clk);
    req_valid = 0; lat = 1;
    while (rsp_valid !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
    if (rsp_valid !== 1'b1) begin to = 1; return; end
    rd = rsp_rdata;
    for (int i = 0; i < rwait; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== rd || req_ready !== 1'b0) stable = 0;
    end
    rsp_ready = 1;
    if (req_ready !== 1'b0) stable = 0;
    @(negedge clk);
    rsp_ready = 0;
    if (rsp_valid !== 1'b0) stable = 0;
  endtask

  task automatic run_and_check(input string tag, input logic we_i, input logic [31:0] a, input logic [31:0] wd,
                               input logic [3:0] m, input int rwait, input logic [31:0] exp_rd,
                               input logic [31:0] exp_line, input logic [15:0] exp_strb, input bit chk_lat);
    logic [31:0] rd;
    int lat, aw0, w0, be0;
    bit stable, to;
    aw0 = aw_hs_n; w0 = w_hs_n; be0 = b_early_n;
    do_req(we_i, a, wd, m, rwait, rd, lat, stable, to);
    chk({tag, "_timeout"}, 128'(to), 128'(0));
    chk({tag, "_rdata"}, 128'(rd), 128'(exp_rd));
    chk({tag, "_stable"}, 128'(stable), 128'(1));
    if (we_i) begin
      chk({tag, "_waddr"}, 128'(last_waddr), 128'(exp_line));
      chk({tag, "_strb"}, 128'(last_wstrb), 128'(exp_strb));
      chk({tag, "_wdata"}, last_wdata, {wd, wd, wd, wd});
      chk({tag, "_aw_hs"}, 128'(aw_hs_n - aw0), 128'(1));
      chk({tag, "_w_hs"}, 128'(w_hs_n - w0), 128'(1));
      chk({tag, "_bresp_early"}, 128'(b_early_n - be0), 128'(0));
    end else begin
      chk({tag, "_raddr"}, 128'(last_raddr), 128'(exp_line));
    end
    if (chk_lat) chk({tag, "_latency"}, 128'(lat), 128'(3));
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    int          rwait;
    logic [31:0] exp_rdata;
    logic [31:0] exp_line;
    logic [15:0] exp_strb;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  initial begin
    int n, wv0, av0;
    bit seen;
    logic        rw;
    logic [31:0] ra, rwd, exp;
    logic [3:0]  rm;

    vecs[0]  = '{1'b0, 32'h0000_0018, 32'h0, 4'h0, 0, 32'h0B0A0908, 32'h10, 16'h0000};
    vecs[1]  = '{1'b0, 32'hFFFF_0018, 32'h0, 4'h0, 0, 32'h0B0A0908, 32'h10, 16'h0000};
    vecs[2]  = '{1'b0, 32'h0000_001B, 32'h0, 4'h0, 2, 32'h0B0A0908, 32'h10, 16'h0000};
    vecs[3]  = '{1'b1, 32'h0000_0024, 32'hDEADBEEF, 4'b0110, 0, 32'h0, 32'h20, 16'h0060};
    vecs[4]  = '{1'b0, 32'h0000_0024, 32'h0, 4'h0, 0, 32'h00ADBE00, 32'h20, 16'h0000};
    vecs[5]  = '{1'b1, 32'h0000_0030, 32'h12345678, 4'b0000, 0, 32'h0, 32'h30, 16'h0000};
    vecs[6]  = '{1'b0, 32'h0000_0030, 32'h0, 4'h0, 0, 32'h55555555, 32'h30, 16'h0000};
    vecs[7]  = '{1'b0, 32'h0000_001C, 32'h0, 4'h0, 0, 32'h0F0E0D0C, 32'h10, 16'h0000};
    vecs[8]  = '{1'b1, 32'h0000_001C, 32'hFFFFFFFF, 4'b1000, 0, 32'h0, 32'h10, 16'h8000};
    vecs[9]  = '{1'b0, 32'h0000_001C, 32'h0, 4'h0, 0, 32'hFF0E0D0C, 32'h10, 16'h0000};
    vecs[10] = '{1'b0, 32'h0000_0010, 32'h0, 4'h0, 5, 32'h03020100, 32'h10, 16'h0000};
    vecs[11] = '{1'b1, 32'hABCD_0050, 32'h01020304, 4'b1111, 0, 32'h0, 32'h50, 16'h000F};
    vecs[12] = '{1'b0, 32'h0000_0050, 32'h0, 4'h0, 0, 32'h01020304, 32'h50, 16'h0000};

    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i]        = 8'hA0 + 8'(i);
      ref_mem[16 + i]   = 8'(i);
      ref_mem[48 + i]   = 8'h55;
    end
    for (int l = 0; l < 4096; l++)
      for (int b = 0; b < 16; b++) lines[l][8*b +: 8] = ref_mem[16*l + b];

    rst_n = 0; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_wmask = '0; rsp_ready = 0;
    repeat (3) @(negedge clk);
    chk("reset_handshakes", 128'({req_ready, rsp_valid, readAddr_valid, readData_ready,
                                  writeAddr_valid, writeData_valid, writeResp_ready}), 128'(0));
    chk("reset_rdata", 128'(rsp_rdata), 128'(0));
    rst_n = 1;
    @(negedge clk);
    chk("ready_after_reset", 128'(req_ready), 128'(1));

    for (int i = 0; i < NV; i++) begin
      run_and_check($sformatf("v%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].mask,
                    vecs[i].rwait, vecs[i].exp_rdata, vecs[i].exp_line, vecs[i].exp_strb, !vecs[i].we);
      if (vecs[i].we) ref_write(vecs[i].addr, vecs[i].wdata, vecs[i].mask);
    end

    // Address handshake delayed 3 cycles, data immediate.
    aw_dly = 3; w_dly = 0; wv0 = wv_cycles; av0 = av_cycles;
    run_and_check("split_aw", 1'b1, 32'h44, 32'h11223344, 4'hF, 0, 32'h0, 32'h40, 16'h00F0, 1'b0);
    ref_write(32'h44, 32'h11223344, 4'hF);
    chk("split_aw_wvalid_cycles", 128'(wv_cycles - wv0), 128'(1));
    chk("split_aw_avalid_cycles", 128'(av_cycles - av0), 128'(4));
    // Data handshake delayed 2 cycles, address immediate.
    aw_dly = 0; w_dly = 2; wv0 = wv_cycles; av0 = av_cycles;
    run_and_check("split_w", 1'b1, 32'h48, 32'hCAFEF00D, 4'b0011, 0, 32'h0, 32'h40, 16'h0300, 1'b0);
    ref_write(32'h48, 32'hCAFEF00D, 4'b0011);
    chk("split_w_wvalid_cycles", 128'(wv_cycles - wv0), 128'(3));
    chk("split_w_avalid_cycles", 128'(av_cycles - av0), 128'(1));
    w_dly = 0;
    run_and_check("rb44", 1'b0, 32'h44, 32'h0, 4'h0, 0, 32'h11223344, 32'h40, 16'h0, 1'b1);
    run_and_check("rb48", 1'b0, 32'h48, 32'h0, 4'h0, 0, 32'h0000F00D, 32'h40, 16'h0, 1'b1);

    // Reset while waiting for read data.
    r_dly = 8;
    @(negedge clk);
    req_valid = 1; req_we = 0; req_addr = 32'h18;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 0;
    n = 0;
    while (readData_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("rst_reached_rdata", 128'(readData_ready), 128'(1));
    rst_n = 0;
    @(negedge clk);
    chk("rst_clears_outputs", 128'({req_ready, readData_ready, rsp_valid}), 128'(0));
    rst_n = 1; r_dly = 0;
    seen = 0;
    repeat (8) begin @(negedge clk); if (rsp_valid !== 1'b0) seen = 1; end
    chk("rst_no_response", 128'(seen), 128'(0));
    chk("rst_ready_again", 128'(req_ready), 128'(1));
    run_and_check("rst_read0", 1'b0, 32'h0, 32'h0, 4'h0, 0, 32'hA3A2A1A0, 32'h0, 16'h0, 1'b1);

    // Randomized traffic against the byte-level reference memory.
    for (int t = 0; t < 200; t++) begin
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      rw  = 1'($urandom_range(0, 1));
      ra  = $urandom & 32'hFFFF_00FF;
      rwd = $urandom;
      rm  = 4'($urandom_range(0, 15));
      exp = rw ? 32'h0 : ref_read(ra);
      run_and_check($sformatf("rnd%0d", t), rw, ra, rwd, rm, $urandom_range(0, 2), exp,
                    {16'h0, ra[15:4], 4'h0}, 16'(rm) << (4 * ra[3:2]), 1'b0);
      if (rw) ref_write(ra, rwd, rm);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_req_bridge.md
MEM_REQ_BRIDGE -- requirements
Module: mem_req_bridge

Interface
REQ-001 The parameter list SHALL be: ADDR_W, default 16, number of low request-address bits forwarded to the AXI side; upper bits are driven 0.
REQ-002 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-003 rst_n  in  1  reset; synchronous, active-low.
REQ-004 req_valid  in  1  requester has a word request.
REQ-005 req_ready  out  1  bridge accepts a request this cycle.
REQ-006 req_we  in  1  1 = write, 0 = read.
REQ-007 req_addr  in  32  byte address; bits [1:0] ignored.
REQ-008 req_wdata  in  32  write word.
REQ-009 req_wmask  in  4  byte enables for req_wdata.
REQ-010 rsp_valid  out  1  response available.
REQ-011 rsp_ready  in  1  requester consumes response.
REQ-012 rsp_rdata  out  32  read word; 0 for write responses.
REQ-013 AXI-Lite master ports SHALL be: readAddr_addr out 32, readAddr_valid out 1, readAddr_ready in 1, readData_data in 128, readData_valid in 1, readData_ready out 1, writeAddr_addr out 32, writeAddr_valid out 1, writeAddr_ready in 1, writeData_data out 128, writeData_strb out 16, writeData_valid out 1, writeData_ready in 1, writeResp_msg in 32 (ignored), writeResp_valid in 1, writeResp_ready out 1.

Function
REQ-014 FSM states SHALL be IDLE, RADDR, RDATA, WRITE, WRESP, RESP; exactly one request in flight.
REQ-015 req_ready SHALL be 1 only in IDLE; on req_valid&req_ready, addr/we/wdata/wmask SHALL be registered and state SHALL go to RADDR (read) or WRITE (write) next cycle.
REQ-016 Line address SHALL be {0, req_addr[ADDR_W-1:4], 4'b0000}, driven on readAddr_addr/writeAddr_addr from registered values.
REQ-017 RADDR: readAddr_valid=1, held until a cycle with readAddr_ready=1, then RDATA.
REQ-018 RDATA: readData_ready=1; on readData_valid=1, capture readData_data[32*k+31:32*k] with k=addr[3:2] into rsp_rdata, go RESP.
REQ-019 WRITE: writeAddr_valid and writeData_valid both asserted on entry; each SHALL drop the cycle after its own handshake and never reassert for the same request; when both handshakes are done (same or different cycles) go WRESP.
REQ-020 writeData_data SHALL be req_wdata replicated 4x; writeData_strb SHALL be req_wmask shifted left by 4*k, all other strobe bits 0.
REQ-021 req_wmask=0 SHALL still issue the full write transaction with writeData_strb=0.
REQ-022 WRESP: writeResp_ready=1; on writeResp_valid=1, rsp_rdata=0, go RESP.
REQ-023 RESP: rsp_valid=1 with stable rsp_rdata until rsp_ready=1, then IDLE; no new request accepted in the same cycle as rsp handshake.
REQ-024 Minimum read latency (req accept to rsp_valid) SHALL be 3 cycles with zero-wait slave; AXI valids SHALL never depend combinationally on AXI readies.
REQ-025 Outputs not named active in a state SHALL be 0.

Reset
REQ-026 While rst_n=0 at a clock edge: state=IDLE, all valid/ready outputs 0 except req_ready which becomes 1 after reset, rsp_rdata=0, capture registers 0.
REQ-027 Reset mid-transaction SHALL abandon the transaction with no response; the following request SHALL be handled normally.

Structure
REQ-028 State encoding and the LINE_BYTES=16 / WORD_BYTES=4 constants SHALL live in shared package mem_pkg.
REQ-029 Single module; the lane select/strobe expansion MAY be a sub-module named word_lane_map.

Verification
REQ-030 Read: preload SRAM 0x0010..0x001F=0x00..0x0F, read addr 0x0018 -> rsp_rdata=0x0B0A0908, readAddr_addr=0x00000010.
REQ-031 Write: addr 0x0024, wdata 0xDEADBEEF, wmask 4'b0110 -> strb=16'h0060, data replicated; read-back 0x0024 -> 0x00ADBE00 over preloaded zeros.
REQ-032 Split write handshake: writeAddr_ready delayed 3 cycles, writeData_ready immediate -> writeData_valid high exactly 1 cycle, WRESP entered only after address handshake.
REQ-033 Backpressure: rsp_ready low 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 throughout.
REQ-034 Reset asserted in RDATA -> no rsp_valid; next read of 0x0000 returns correct data.
REQ-035 Zero mask write to 0x0030 -> transaction completes, memory unchanged, rsp_rdata=0.
